// File: rtl/cla_multicycle_add_ctrl.sv
// Area-lean WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice is
// reused once per nibble, LSB first, with the inter-slice carry held in a register.
module cla_multicycle_add_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_chk
        $error("cla_multicycle_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opA, r_opB, r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry, r_cout, r_ovf;
    logic             r_in_ready, r_out_valid, r_busy;

    logic [3:0] w_sa, w_sb, w_p, w_g, w_c, w_ssum;
    logic       w_pg, w_gg, w_scout, w_last;

    assign w_sa = r_opA[4*r_idx +: 4];
    assign w_sb = r_opB[4*r_idx +: 4];
    assign w_p  = w_sa ^ w_sb;
    assign w_g  = w_sa & w_sb;

    // Two-level lookahead carries inside the slice; only the group carry crosses cycles.
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & r_carry);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    assign w_pg   = &w_p;
    assign w_gg   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign w_scout = w_gg | (w_pg & r_carry);
    assign w_ssum  = w_p ^ w_c;
    assign w_last  = (r_idx == IW'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_opA       <= '0;
            r_opB       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_opA      <= a;
                        r_opB      <= sub ? ~b : b;
                        r_carry    <= sub ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum[4*r_idx +: 4] <= w_ssum;
                    r_carry             <= w_scout;
                    if (w_last) begin
                        // Slice sum bit 3 is the result MSB on the last pass.
                        r_cout      <= w_scout;
                        r_ovf       <= (r_opA[WIDTH-1] == r_opB[WIDTH-1])
                                     & (w_ssum[3] != r_opA[WIDTH-1]);
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;
    assign busy      = r_busy;
endmodule

// File: doc/cla_multicycle_add_ctrl.md
Name: cla_multicycle_add_ctrl

Overview:
- Sequencer that reuses a single 4-bit carry-lookahead slice (4-bit sum plus group P/G) to add or subtract WIDTH-bit operands.
- Processes one nibble per clock, least-significant first, and holds the inter-slice carry in a register.
- Used where area matters more than latency. Operands come in and results go out through a valid/ready handshake.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NSLICE, WIDTH/4, derived slice count; not overridden by users.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands are valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- overflow  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, overflow=0, carry register=0, slice index=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge, latch a into opA and b into opB, with opB = ~b when sub=1.
  - Load the carry register with sub ? 1 : cin, set idx=0, and go to RUN.
- RUN:
  - Each cycle, slice inputs are opA[4*idx+:4], opB[4*idx+:4] and the carry register.
  - Slice carry-out = Gg | (Pg & carry).
  - At the edge: write the slice sum into sum[4*idx+:4], load the slice carry-out into the carry register, and increment idx.
  - After slice NSLICE-1: cout = that slice's carry-out, go to DONE.
  - overflow = (opA[MSB] == opB[MSB]) & (sum[MSB] != opA[MSB]), using the effective (possibly inverted) opB. It is registered on entry to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are stable.
  - On out_ready go to IDLE at the same edge and drop out_valid. sum/cout/overflow hold their values until the next accept.
- Latency:
  - out_valid rises exactly NSLICE cycles after the accept edge.
  - With out_ready held high, the minimum time from one accept to the next is NSLICE+2 cycles.
  - WIDTH=4 gives 1 RUN cycle.
- Input changes after acceptance have no effect, because operands and sub are latched.
- in_valid asserted in RUN/DONE is not accepted (in_ready=0). The producer must hold it until it is accepted.
- out_ready asserted outside DONE is ignored.
- No accept occurs in the same cycle as DONE->IDLE; a new accept is possible on the following cycle.
- rst mid-RUN or mid-DONE: the result is discarded and every output takes its reset value on the next edge. rst has priority over all handshakes.
- The slice index wraps only via return to IDLE. idx never exceeds NSLICE-1.
- During RUN, sum contains partially written nibbles (upper bits from the previous op). sum is only valid while out_valid=1.

Test Plan (WIDTH=16):
1. Add: a=0x00FF, b=0x0001, cin=0, sub=0 -> out_valid 4 cycles after accept; sum=0x0100, cout=0, overflow=0.
2. Full carry chain: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Signed overflow and subtract:
   - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1.
   - sub: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0.
   - sub: a=0x8000, b=0x0001 -> sum=0x7FFF, overflow=1, cout=1.
4. Backpressure and ignored inputs:
   - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum and cout stay stable, in_ready=0.
   - A second in_valid with new a/b during RUN is not accepted and does not corrupt the result.
   - After out_ready, the pending operands are accepted one cycle later.
5. Reset mid-operation: assert rst for 1 cycle at RUN idx=2 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0, cout=0. A subsequent 0x1234+0x4321 gives 0x5555.
6. Random back-to-back: 1000 random a/b/cin/sub with random out_ready gaps -> every result matches the A+B+cin / A-B reference model for sum, cout and overflow, and out_valid latency is always exactly 4.
